regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the datapath: NRD combinational read ports, two write

---
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two write ports,
// optional write-to-read bypass and a per-register load-busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 32,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = 31,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_a,
    input  logic [ADDR_W-1:0]     wa_a,
    input  logic [DATA_W-1:0]     wd_a,
    input  logic                  we_b,
    input  logic [ADDR_W-1:0]     wa_b,
    input  logic [DATA_W-1:0]     wd_b,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    output logic [NREGS-1:0]      busy_vec
);

    // Registers that hold state; the zero register is never written or marked busy.
    function automatic logic [NREGS-1:0] live_mask();
        logic [NREGS-1:0] m;
        for (int r = 0; r < NREGS; r++) begin
            m[r] = !(ZERO_EN != 0 && r == ZERO_REG);
        end
        return m;
    endfunction

    localparam logic [NREGS-1:0] LIVE = live_mask();

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            if (LIVE[r]) begin
                if (we_b && wa_b == ADDR_W'(r)) begin
                    regs_d[r] = wd_b;
                end else if (we_a && wa_a == ADDR_W'(r)) begin
                    regs_d[r] = wd_a;
                end
                // A new load to the same register outranks the returning one.
                if (sb_set && sb_addr == ADDR_W'(r)) begin
                    busy_d[r] = 1'b1;
                end else if (we_b && wa_b == ADDR_W'(r)) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              bsy;
    logic              hit;

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        addr    = '0;
        val     = '0;
        bsy     = 1'b0;
        hit     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            addr = ra[i*ADDR_W +: ADDR_W];
            val  = '0;
            bsy  = 1'b0;
            hit  = 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                if (LIVE[r] && addr == ADDR_W'(r)) begin
                    hit = 1'b1;
                    val = regs_q[r];
                    bsy = busy_q[r];
                end
            end
            if (BYPASS != 0 && hit) begin
                if (we_b && wa_b == addr) begin
                    val = wd_b;
                    bsy = 1'b0;
                end else if (we_a && wa_a == addr) begin
                    val = wd_a;
                end
            end
            // Bypassed write data must not leak out while reset is held.
            if (!reset_n) begin
                val = '0;
                bsy = 1'b0;
            end
            rd[i*DATA_W +: DATA_W] = val;
            rd_busy[i]             = bsy;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypassing and non-bypassing
// instances share stimulus and are checked against one reference model.
module tb_regfile_mp;

    logic         clk;
    logic         reset_n;
    logic         we_a;
    logic [4:0]   wa_a;
    logic [63:0]  wd_a;
    logic         we_b;
    logic [4:0]   wa_b;
    logic [63:0]  wd_b;
    logic [9:0]   ra;
    logic [127:0] rd;
    logic [127:0] rd_nb;
    logic [1:0]   rb;
    logic [1:0]   rb_nb;
    logic         sb_set;
    logic [4:0]   sb_addr;
    logic [31:0]  bv;
    logic [31:0]  bv_nb;

    regfile_mp dut (
        .clk(clk), .reset_n(reset_n),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra(ra), .rd(rd), .rd_busy(rb),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(bv)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
        .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ra(ra), .rd(rd_nb), .rd_busy(rb_nb),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(bv_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd0, rd1, nb0, nb1;
        logic [1:0]  rb, nbb;
        logic [31:0] bv;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_reg [32];
    logic [31:0] m_busy;
    int          nvec = 0;
    int          nmis = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] mrd(input logic [4:0] a, input bit byp);
        if (!reset_n || a == 5'd31) return 64'h0;
        if (byp && we_b && wa_b == a) return wd_b;
        if (byp && we_a && wa_a == a) return wd_a;
        return m_reg[a];
    endfunction

    function automatic logic mbusy(input logic [4:0] a, input bit byp);
        if (!reset_n || a == 5'd31) return 1'b0;
        if (byp && we_b && wa_b == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) m_reg[r] = 64'h0;
        m_busy = 32'h0;
    endtask

    task automatic m_edge();
        logic [31:0] nb;
        if (!reset_n) return;
        nb = m_busy;
        for (int r = 0; r < 31; r++) begin
            if (we_b && wa_b == 5'(r)) m_reg[r] = wd_b;
            else if (we_a && wa_a == 5'(r)) m_reg[r] = wd_a;
            if (sb_set && sb_addr == 5'(r)) nb[r] = 1'b1;
            else if (we_b && wa_b == 5'(r)) nb[r] = 1'b0;
        end
        m_busy = nb;
    endtask

    task automatic push_exp();
        exp_t e;
        e.rd0 = mrd(ra[4:0], 1'b1);
        e.rd1 = mrd(ra[9:5], 1'b1);
        e.nb0 = mrd(ra[4:0], 1'b0);
        e.nb1 = mrd(ra[9:5], 1'b0);
        e.rb  = {mbusy(ra[9:5], 1'b1), mbusy(ra[4:0], 1'b1)};
        e.nbb = {mbusy(ra[9:5], 1'b0), mbusy(ra[4:0], 1'b0)};
        e.bv  = m_busy;
        q.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, ".q"}, 64'h0, 64'h1);
            return;
        end
        e = q.pop_front();
        chk({tag, ".rd0"}, rd[63:0], e.rd0);
        chk({tag, ".rd1"}, rd[127:64], e.rd1);
        chk({tag, ".nb0"}, rd_nb[63:0], e.nb0);
        chk({tag, ".nb1"}, rd_nb[127:64], e.nb1);
        chk({tag, ".rb"}, 64'(rb), 64'(e.rb));
        chk({tag, ".nbb"}, 64'(rb_nb), 64'(e.nbb));
        chk({tag, ".bv"}, 64'(bv), 64'(e.bv));
        chk({tag, ".bvnb"}, 64'(bv_nb), 64'(e.bv));
    endtask

    task automatic step(input string tag);
        push_exp();
        #2;
        pop_chk(tag);
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        we_a = 1'b0; wa_a = '0; wd_a = '0;
        we_b = 1'b0; wa_b = '0; wd_b = '0;
        sb_set = 1'b0; sb_addr = '0;
        ra = {r1, r0};
    endtask

    initial begin
        reset_n = 1'b0;
        m_clear();
        idle(5'd0, 5'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 4; k++) begin
            idle(5'($urandom_range(0, 31)), 5'd5);
            we_a = 1'b1; wa_a = 5'($urandom_range(0, 30));
            wd_a = {$urandom, $urandom};
            we_b = 1'b1; wa_b = 5'd5; wd_b = {$urandom, $urandom};
            sb_set = 1'b1; sb_addr = 5'($urandom_range(0, 30));
            step("wr");
        end
        idle(5'd5, wa_a);
        reset_n = 1'b0;
        m_clear();
        step("rst_hold");
        reset_n = 1'b1;
        idle(5'd5, 5'd0);
        step("rst_rel");

        idle(5'd5, 5'd0);
        we_a = 1'b1; wa_a = 5'd5; wd_a = 64'hDEAD_BEEF;
        step("wr5");
        idle(5'd5, 5'd0);
        step("rd5");
        idle(5'd31, 5'd5);
        we_a = 1'b1; wa_a = 5'd31; wd_a = 64'h1;
        step("wr31");
        idle(5'd31, 5'd31);
        step("rd31");

        idle(5'd5, 5'd7);
        we_a = 1'b1; wa_a = 5'd7; wd_a = 64'h11;
        we_b = 1'b1; wa_b = 5'd7; wd_b = 64'h22;
        step("dual");
        idle(5'd5, 5'd7);
        step("dual_rd");

        idle(5'd9, 5'd7);
        sb_set = 1'b1; sb_addr = 5'd9;
        step("sb9");
        idle(5'd9, 5'd7);
        step("sb9_busy");
        idle(5'd9, 5'd7);
        we_b = 1'b1; wa_b = 5'd9; wd_b = 64'h5;
        step("clr9");
        idle(5'd9, 5'd7);
        step("clr9_done");

        idle(5'd3, 5'd9);
        sb_set = 1'b1; sb_addr = 5'd3;
        step("sb3");
        idle(5'd3, 5'd9);
        sb_set = 1'b1; sb_addr = 5'd3;
        we_b = 1'b1; wa_b = 5'd3; wd_b = 64'h33;
        step("coll3");
        idle(5'd3, 5'd9);
        we_a = 1'b1; wa_a = 5'd3; wd_a = 64'h44;
        step("wa3");
        idle(5'd3, 5'd9);
        step("rd3");

        idle(5'd4, 5'd3);
        sb_set = 1'b1; sb_addr = 5'd4;
        step("sb4");
        idle(5'd4, 5'd3);
        we_a = 1'b1; wa_a = 5'd4; wd_a = 64'h77;
        sb_set = 1'b1; sb_addr = 5'd6;
        #2;
        reset_n = 1'b0;
        m_clear();
        #1;
        push_exp();
        pop_chk("mid_rst");
        @(posedge clk);
        m_edge();
        @(negedge clk);
        reset_n = 1'b1;
        idle(5'd4, 5'd6);
        step("post_rst");

        for (int k = 0; k < 40; k++) begin
            idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            we_a = 1'($urandom); wa_a = 5'($urandom_range(0, 31));
            wd_a = {$urandom, $urandom};
            we_b = 1'($urandom); wa_b = 5'($urandom_range(0, 31));
            wd_b = {$urandom, $urandom};
            sb_set = 1'($urandom); sb_addr = 5'($urandom_range(0, 31));
            if (k % 3 == 0) ra[4:0] = wa_b;
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
